// File: rtl/mptw_flush_controller_pkg.sv
// Shared types for the MPT walker flush controller.
//   mptw_flush_ctrl_e   : per-stage flush command (NONE / ALL / SPEC / UNUSED)
//   mptw_flush_status_e : per-stage flush status (IDLE / ONGOING / COMPLETED / UNUSED)
//   mptw_flush_fsm_e    : controller state (IDLE / FLUSH / DONE)
package mptw_flush_controller_pkg;

  typedef enum logic [1:0] {
    FLUSH_NONE   = 2'b00,
    FLUSH_ALL    = 2'b01,
    FLUSH_SPEC   = 2'b10,
    FLUSH_UNUSED = 2'b11
  } mptw_flush_ctrl_e;

  typedef enum logic [1:0] {
    FSTAT_IDLE      = 2'b00,
    FSTAT_ONGOING   = 2'b01,
    FSTAT_COMPLETED = 2'b10,
    FSTAT_UNUSED    = 2'b11
  } mptw_flush_status_e;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'b00,
    FSM_FLUSH = 2'b01,
    FSM_DONE  = 2'b10
  } mptw_flush_fsm_e;

  // Only ALL and SPEC start a flush; NONE and UNUSED are consumed silently.
  function automatic logic is_valid_flush(mptw_flush_ctrl_e t);
    return (t == FLUSH_ALL) || (t == FLUSH_SPEC);
  endfunction

endpackage

// File: rtl/mptw_flush_controller_if.sv
// Bundle of the core-side flush handshake and the per-stage command/status
// buses of the MPT walker flush controller.
//   master : core + walker stages (drive request, type, stage status)
//   slave  : flush controller (drives ready, stage commands, stall, done, error, busy)
interface mptw_flush_controller_if
  import mptw_flush_controller_pkg::*;
#(
  parameter int NUM_STAGES = 4
) ();

  logic                                 flush_req_i;
  mptw_flush_ctrl_e                     flush_type_i;
  logic                                 flush_ready_o;
  mptw_flush_ctrl_e   [NUM_STAGES-1:0]  stage_flush_o;
  mptw_flush_status_e [NUM_STAGES-1:0]  stage_status_i;
  logic                                 stall_issue_o;
  logic                                 flush_done_o;
  logic                                 flush_error_o;
  logic                                 busy_o;

  modport master (
    output flush_req_i, flush_type_i, stage_status_i,
    input  flush_ready_o, stage_flush_o, stall_issue_o,
           flush_done_o, flush_error_o, busy_o
  );

  modport slave (
    input  flush_req_i, flush_type_i, stage_status_i,
    output flush_ready_o, stage_flush_o, stall_issue_o,
           flush_done_o, flush_error_o, busy_o
  );

endinterface

// File: rtl/mptw_flush_stage_tracker.sv
// Per-stage flush bookkeeping: remembers whether the stage has acknowledged
// the current flush and whether it has completed it, and drives that stage's
// flush command.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   i_clear       : a new flush was accepted; clear the masks
//   i_active      : controller is in FLUSH (status is ignored otherwise)
//   i_type        : latched flush type
//   i_status      : stage flush status
//   o_flush       : stage flush command
//   o_done_now    : stage has completed, including a COMPLETED seen this cycle
module mptw_flush_stage_tracker
  import mptw_flush_controller_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               i_clear,
  input  logic               i_active,
  input  mptw_flush_ctrl_e   i_type,
  input  mptw_flush_status_e i_status,
  output mptw_flush_ctrl_e   o_flush,
  output logic               o_done_now
);

  logic r_acked;
  logic r_completed;
  logic w_ack_now;
  logic w_cpl_now;

  // COMPLETED is only a one-cycle pulse, so it must be captured the cycle it appears.
  assign w_cpl_now = i_active && (i_status == FSTAT_COMPLETED);
  assign w_ack_now = i_active &&
                     ((i_status == FSTAT_ONGOING) || (i_status == FSTAT_COMPLETED));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acked     <= 1'b0;
      r_completed <= 1'b0;
    end else if (i_clear) begin
      r_acked     <= 1'b0;
      r_completed <= 1'b0;
    end else begin
      if (w_ack_now) r_acked     <= 1'b1;
      if (w_cpl_now) r_completed <= 1'b1;
    end
  end

  assign o_done_now = r_completed | w_cpl_now;
  assign o_flush    = (i_active && !r_acked) ? i_type : FLUSH_NONE;

endmodule

// File: rtl/mptw_flush_controller.sv
// MPT walker flush controller. Accepts one ALL/SPEC flush request, broadcasts
// it to every walker stage until each stage acknowledges, waits for every
// stage to report COMPLETED (or for the timeout), then pulses done (and error
// on timeout). Issue is stalled for the whole operation.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : slave side of mptw_flush_controller_if
//            (flush_req_i, flush_type_i, flush_ready_o, stage_flush_o,
//             stage_status_i, stall_issue_o, flush_done_o, flush_error_o, busy_o)
module mptw_flush_controller
  import mptw_flush_controller_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  mptw_flush_controller_if.slave bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mptw_flush_fsm_e                 r_state;
  mptw_flush_fsm_e                 w_state_next;
  mptw_flush_ctrl_e                r_type;
  logic [CNT_W-1:0]                r_cnt;
  logic                            r_err;
  logic                            w_accept;
  logic                            w_timeout;
  logic                            w_in_flush;
  logic                            w_all_done;
  logic [NUM_STAGES-1:0]           w_done_now;
  mptw_flush_ctrl_e [NUM_STAGES-1:0] w_stage_flush;

  assign w_in_flush = (r_state == FSM_FLUSH);
  assign w_all_done = &w_done_now;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= FSM_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      FSM_IDLE: begin
        if (bus.flush_req_i && is_valid_flush(bus.flush_type_i)) begin
          w_accept     = 1'b1;
          w_state_next = FSM_FLUSH;
        end
      end
      FSM_FLUSH: begin
        // Completion wins over a timeout landing on the same cycle.
        if (w_all_done) begin
          w_state_next = FSM_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = FSM_DONE;
        end
      end
      FSM_DONE: w_state_next = FSM_IDLE;
      default:  w_state_next = FSM_IDLE;
    endcase
  end

  // Latched type, timeout counter and error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_type <= FLUSH_NONE;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_type <= bus.flush_type_i;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (w_in_flush) begin
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (!w_all_done && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (r_state == FSM_DONE) begin
      r_err <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    mptw_flush_stage_tracker u_tracker (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_clear    (w_accept),
      .i_active   (w_in_flush),
      .i_type     (r_type),
      .i_status   (bus.stage_status_i[g]),
      .o_flush    (w_stage_flush[g]),
      .o_done_now (w_done_now[g])
    );
  end

  assign bus.stage_flush_o = w_stage_flush;
  assign bus.flush_ready_o = (r_state == FSM_IDLE);
  assign bus.busy_o        = (r_state != FSM_IDLE);
  assign bus.stall_issue_o = (r_state != FSM_IDLE);
  assign bus.flush_done_o  = (r_state == FSM_DONE);
  assign bus.flush_error_o = (r_state == FSM_DONE) && r_err;

endmodule
